// File: rtl/mealy_ctrl_pkg.sv
// Shared types and constants for the mealy_ctrl go/ack controller.
package mealy_ctrl_pkg;

    typedef enum logic [2:0] {
        START   = 3'd0,
        COMPUTE = 3'd1,
        FINISH  = 3'd2,
        RESTART = 3'd3,
        ERROR   = 3'd4
    } state_t;

    // Selectors for the done output mode.
    localparam int DONE_LEVEL = 0;
    localparam int DONE_PULSE = 1;

endpackage

// File: rtl/mealy_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/mealy_ctrl.sv
// Mealy go/ack controller: en/done react to inputs in the same cycle,
// with an enable-cycle counter, optional timeout/error state and abort.
module mealy_ctrl #(
    parameter int CNT_WIDTH  = 8,
    parameter int TIMEOUT    = 100,
    parameter int DONE_PULSE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_go,
    input  logic                   i_ack,
    input  logic                   i_abort,
    output logic                   o_en,
    output logic                   o_done,
    output logic                   o_err,
    output logic [CNT_WIDTH-1:0]   o_cycles,
    output mealy_ctrl_pkg::state_t o_state
);
    import mealy_ctrl_pkg::*;

    // done is held through FINISH/RESTART only in level mode.
    localparam logic DONE_HOLD = (DONE_PULSE == mealy_ctrl_pkg::DONE_LEVEL);
    localparam logic TO_EN     = (TIMEOUT != 0);

    state_t               r_state;
    state_t               w_next;
    logic                 w_en;
    logic                 w_done;
    logic                 w_clr;
    logic                 w_inc;
    logic                 w_timeout;
    logic [CNT_WIDTH-1:0] w_count;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .inc   (w_inc),
        .count (w_count)
    );

    assign w_timeout = TO_EN && (w_count == CNT_WIDTH'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= START;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_en   = 1'b0;
        w_done = 1'b0;
        w_clr  = 1'b0;
        w_inc  = 1'b0;
        case (r_state)
            START: begin
                if (i_go) begin
                    w_next = COMPUTE;
                    w_clr  = 1'b1;
                end
            end
            COMPUTE: begin
                // abort outranks ack, and ack outranks the timeout.
                if (i_abort) begin
                    w_next = START;
                end else if (i_ack) begin
                    w_done = 1'b1;
                    w_next = FINISH;
                end else if (w_timeout) begin
                    w_next = ERROR;
                end else begin
                    w_en  = 1'b1;
                    w_inc = 1'b1;
                end
            end
            FINISH: begin
                w_done = DONE_HOLD;
                if (!i_go) begin
                    w_next = RESTART;
                end
            end
            RESTART: begin
                if (i_go) begin
                    w_next = COMPUTE;
                    w_clr  = 1'b1;
                end else begin
                    w_done = DONE_HOLD;
                end
            end
            ERROR: begin
                if (!i_go) begin
                    w_next = START;
                end
            end
            default: begin
                w_next = START;
            end
        endcase
    end

    assign o_en     = w_en;
    assign o_done   = w_done;
    assign o_err    = (r_state == ERROR);
    assign o_cycles = w_count;
    assign o_state  = r_state;

endmodule

// File: tb/tb_mealy_ctrl.sv
// Directed bench for mealy_ctrl: four parameterisations share one stimulus
// stream and are each checked every cycle against a behavioural model.
module tb_mealy_ctrl;
    import mealy_ctrl_pkg::*;

    localparam int N = 4;
    localparam int PH_IDLE = 0, PH_BUSY = 1, PH_FIN = 2, PH_WAIT = 3, PH_ERR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go = 1'b0, ack = 1'b0, abort = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic       en_w[N], done_w[N], err_w[N];
    logic [7:0] cyc_w[N];
    state_t     st_w[N];
    logic [7:0] cyc0, cyc1, cyc2;
    logic [2:0] cyc3;

    int ph[N], cnt[N], en_cnt[N], done_cnt[N];

    always #5 clk = ~clk;

    // u0 default, u1 pulse-done, u2 TIMEOUT=10, u3 3-bit counter without timeout
    mealy_ctrl #(.CNT_WIDTH(8), .TIMEOUT(100), .DONE_PULSE(0)) u0 (
        .clk(clk), .rst(rst), .i_go(go), .i_ack(ack), .i_abort(abort),
        .o_en(en_w[0]), .o_done(done_w[0]), .o_err(err_w[0]), .o_cycles(cyc0), .o_state(st_w[0]));
    mealy_ctrl #(.CNT_WIDTH(8), .TIMEOUT(100), .DONE_PULSE(1)) u1 (
        .clk(clk), .rst(rst), .i_go(go), .i_ack(ack), .i_abort(abort),
        .o_en(en_w[1]), .o_done(done_w[1]), .o_err(err_w[1]), .o_cycles(cyc1), .o_state(st_w[1]));
    mealy_ctrl #(.CNT_WIDTH(8), .TIMEOUT(10), .DONE_PULSE(0)) u2 (
        .clk(clk), .rst(rst), .i_go(go), .i_ack(ack), .i_abort(abort),
        .o_en(en_w[2]), .o_done(done_w[2]), .o_err(err_w[2]), .o_cycles(cyc2), .o_state(st_w[2]));
    mealy_ctrl #(.CNT_WIDTH(3), .TIMEOUT(0), .DONE_PULSE(0)) u3 (
        .clk(clk), .rst(rst), .i_go(go), .i_ack(ack), .i_abort(abort),
        .o_en(en_w[3]), .o_done(done_w[3]), .o_err(err_w[3]), .o_cycles(cyc3), .o_state(st_w[3]));

    assign cyc_w[0] = cyc0;
    assign cyc_w[1] = cyc1;
    assign cyc_w[2] = cyc2;
    assign cyc_w[3] = {5'b0, cyc3};

    function automatic int p_cw(input int i);
        return (i == 3) ? 3 : 8;
    endfunction
    function automatic int p_to(input int i);
        case (i)
            2:       return 10;
            3:       return 0;
            default: return 100;
        endcase
    endfunction
    function automatic int p_dp(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: expected outputs from the behavioural rules, then advance a phase.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            int e_en, e_done, e_err, e_cyc, nph, ncnt, mx;
            mx     = (1 << p_cw(i)) - 1;
            e_en   = 0;
            e_done = 0;
            e_err  = (ph[i] == PH_ERR) ? 1 : 0;
            e_cyc  = cnt[i];
            nph    = ph[i];
            ncnt   = cnt[i];
            if (rst) begin
                e_err = 0;
                e_cyc = 0;
                nph   = PH_IDLE;
                ncnt  = 0;
            end else begin
                case (ph[i])
                    PH_IDLE: if (go) begin nph = PH_BUSY; ncnt = 0; end
                    PH_BUSY: begin
                        if (abort) nph = PH_IDLE;
                        else if (ack) begin e_done = 1; nph = PH_FIN; end
                        else if (p_to(i) != 0 && cnt[i] == p_to(i)) nph = PH_ERR;
                        else begin
                            e_en = 1;
                            if (cnt[i] < mx) ncnt = cnt[i] + 1;
                        end
                    end
                    PH_FIN: begin
                        e_done = 1 - p_dp(i);
                        if (!go) nph = PH_WAIT;
                    end
                    PH_WAIT: begin
                        if (go) begin nph = PH_BUSY; ncnt = 0; end
                        else e_done = 1 - p_dp(i);
                    end
                    default: if (!go) nph = PH_IDLE;
                endcase
                en_cnt[i]   += int'(en_w[i]);
                done_cnt[i] += int'(done_w[i]);
            end
            chk($sformatf("u%0d en", i),     int'(en_w[i]),   e_en);
            chk($sformatf("u%0d done", i),   int'(done_w[i]), e_done);
            chk($sformatf("u%0d err", i),    int'(err_w[i]),  e_err);
            chk($sformatf("u%0d cycles", i), int'(cyc_w[i]),  e_cyc);
            ph[i]  = nph;
            cnt[i] = ncnt;
        end
    end

    task automatic cyc(input logic g, input logic a, input logic b);
        go    = g;
        ack   = a;
        abort = b;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            en_cnt[i]   = 0;
            done_cnt[i] = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ph[i] = PH_IDLE;
            cnt[i] = 0;
        end
        clear_counts();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset en", int'(en_w[0]), 0);
        chk("reset done", int'(done_w[0]), 0);
        chk("reset err", int'(err_w[0]), 0);
        chk("reset cycles", int'(cyc_w[0]), 0);
        chk("reset state", int'(st_w[0]), int'(START));

        // Basic handshake: ack on the 5th COMPUTE cycle
        clear_counts();
        cyc(1, 0, 0);
        repeat (4) cyc(1, 0, 0);
        cyc(1, 1, 0);
        repeat (3) cyc(0, 0, 0);
        chk("basic en cycles", en_cnt[0], 4);
        chk("basic cycles", int'(cyc_w[0]), 4);
        chk("basic done level cycles", done_cnt[0], 4);
        chk("basic done pulse cycles", done_cnt[1], 1);
        chk("basic err", int'(err_w[0]), 0);

        // Long run: u2 times out, u3 saturates
        clear_counts();
        cyc(1, 0, 0);
        repeat (20) cyc(1, 0, 0);
        chk("timeout en cycles", en_cnt[2], 10);
        chk("timeout err", int'(err_w[2]), 1);
        chk("timeout state", int'(st_w[2]), int'(ERROR));
        chk("sat cycles", int'(cyc_w[3]), 7);
        chk("sat err", int'(err_w[3]), 0);
        chk("long cycles", int'(cyc_w[0]), 20);
        cyc(0, 0, 0);
        chk("error cleared", int'(err_w[2]), 0);
        chk("error to start", int'(st_w[2]), int'(START));

        // Asynchronous reset mid-COMPUTE
        chk("pre-reset en", int'(en_w[0]), 1);
        rst = 1'b1;
        #1;
        chk("async rst en", int'(en_w[0]), 0);
        chk("async rst cycles", int'(cyc_w[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // abort together with ack on the 3rd COMPUTE cycle
        clear_counts();
        cyc(1, 0, 0);
        repeat (2) cyc(1, 0, 0);
        cyc(1, 1, 1);
        chk("abort state", int'(st_w[0]), int'(START));
        cyc(0, 0, 0);
        chk("abort cycles", int'(cyc_w[0]), 2);
        chk("abort done cycles", done_cnt[0], 0);
        chk("abort en cycles", en_cnt[0], 2);

        // go held after completion, then fall/rise to restart
        clear_counts();
        cyc(1, 0, 0);
        repeat (3) cyc(1, 0, 0);
        cyc(1, 1, 0);
        repeat (5) cyc(1, 0, 0);
        chk("hold state", int'(st_w[0]), int'(FINISH));
        chk("hold done", int'(done_w[0]), 1);
        chk("hold pulse done", int'(done_w[1]), 0);
        chk("hold pulse count", done_cnt[1], 1);
        cyc(0, 0, 0);
        go = 1'b1;
        #1;
        chk("restart done falls", int'(done_w[0]), 0);
        chk("restart state", int'(st_w[0]), int'(RESTART));
        @(posedge clk);
        #1;
        chk("rerun state", int'(st_w[0]), int'(COMPUTE));
        chk("rerun cycles", int'(cyc_w[0]), 0);
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        repeat (3) cyc(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mealy_ctrl.md
# mealy_ctrl

Parametrised Mealy go/ack controller for a compute datapath. It starts work on `go` and drives `en` combinationally until `ack`, flagging `done` on the completing transition. Beyond the basic handshake it adds an enable-cycle counter, an optional timeout with an error state, an abort input, and a level/pulse mode for `done`. It sits between a host handshake and a datapath whose `ack` marks completion.

## Interface
- `CNT_WIDTH`, default 8: width of the enable-cycle counter.
- `TIMEOUT`, default 100: maximum enable cycles before error. 0 disables the timeout. Must be < 2**CNT_WIDTH.
- `DONE_PULSE`, default 0:
  - 0: `done` is a level held through FINISH/RESTART.
  - 1: `done` is a single cycle on the COMPUTE→FINISH transition only.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `go` in 1: start request, level.
- `ack` in 1: datapath completion.
- `abort` in 1: cancel the current computation.
- `en` out 1: datapath enable, Mealy (combinational from state and inputs).
- `done` out 1: completion, Mealy.
- `err` out 1: timeout error, Moore (high only in ERROR).
- `cycles` out CNT_WIDTH: registered count of `en`-high cycles in the last/current computation.

## Operation
- States: START, COMPUTE, FINISH, RESTART, ERROR.
- START:
  - `en`=0, `done`=0.
  - `go` → COMPUTE and clear `cycles` to 0.
  - Otherwise stay.
- COMPUTE: evaluate in priority order.
  1. `abort`: `en`=0, `done`=0 → START. `cycles` holds.
  2. `ack`: `en`=0, `done`=1 → FINISH.
  3. TIMEOUT≠0 and `cycles`==TIMEOUT: `en`=0, `done`=0 → ERROR.
  4. Otherwise: `en`=1, `done`=0. Stay, and increment `cycles`.
- `cycles` saturates at 2**CNT_WIDTH−1 and never wraps.
- FINISH:
  - `en`=0, `done`=!DONE_PULSE.
  - `go` high → stay.
  - `go` low → RESTART.
- RESTART:
  - `en`=0.
  - `go` → COMPUTE with `done`=0, and clear `cycles`.
  - Otherwise `done`=!DONE_PULSE and stay.
- ERROR:
  - `en`=0, `done`=0, `err`=1.
  - `go` low → START.
  - `go` high → stay, so the host must drop `go` to clear the error.
- `abort` is ignored outside COMPUTE.

## Timing
- Reset state: START, `cycles`=0. Resulting outputs: `en`=0, `done`=0, `err`=0.
  - Reset asserted mid-COMPUTE drops `en` in the same instant (asynchronous).
- `en` and `done` respond to `ack`, `abort` and `go` in the same cycle (zero latency, Mealy).
- The cycle with `ack`=1 in COMPUTE has `en`=0. That cycle is not counted.
- Timeout: with TIMEOUT=N and no `ack`, `en` is high for exactly N cycles. The (N+1)th COMPUTE cycle has `en`=0, then `err`=1 from the next edge.
- If `ack` and the timeout condition occur in the same cycle, `ack` wins.
- If `abort` and `ack` occur in the same cycle, `abort` wins and `done` stays 0.
- `go` held continuously after completion keeps the FSM in FINISH. A new computation requires `go` to fall then rise (via RESTART).
- `cycles` updates on the edge after an `en`-high cycle. It is stable from FINISH until the next start.

## Structure
- Package `mealy_ctrl_pkg` holds:
  - `state_t`: enum logic [2:0] {START, COMPUTE, FINISH, RESTART, ERROR}.
  - Shared `done` mode constants `DONE_LEVEL`=0 and `DONE_PULSE`=1.
- Implementation is 2-process:
  - `always_ff` for the state and counter registers.
  - `always_comb` for next state and Mealy outputs, with defaults assigned at the top.
- Sub-module `sat_counter`: parameter WIDTH; ports clk, rst, clr, inc, count. Clear has priority over increment; the count saturates at its maximum.

## Test plan
- Reset, then `go`=1 with `ack` at the 5th COMPUTE cycle → `en` high for 4 cycles, `done`=1 in the `ack` cycle, `cycles`=4, `err`=0.
- DONE_PULSE=1, same stimulus → `done` high for exactly 1 cycle. `done`=0 throughout FINISH/RESTART.
- TIMEOUT=10, `go`=1, no `ack` → `en` high for 10 cycles, then `err`=1. `go` drop → START with `err`=0.
- `abort` at the 3rd COMPUTE cycle together with `ack`=1 → `en`=0, `done`=0, return to START, `cycles`=2.
- `go` held high after completion → remains in FINISH with `done`=1. `go` low for 1 cycle then high → COMPUTE, `done` falls in the `go` cycle, `cycles` cleared.
- TIMEOUT=0, CNT_WIDTH=3, no `ack` for 20 cycles → `cycles` saturates at 7 and `err` never asserts. `rst` pulse mid-COMPUTE → `en`=0 immediately, `cycles`=0.
